// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel button debouncer with a shared sample tick
// Each channel is synchronized, sampled on the tick, and changes level only after DEPTH equal samples.
module debouncer_multi #(
  parameter int CHANNELS      = 4,
  parameter int DIV_THRESHOLD = 5,
  parameter int DEPTH         = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] buttonIn,
  output logic [CHANNELS-1:0] buttonOut,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released
);

  localparam int CW = (DIV_THRESHOLD > 1) ? $clog2(DIV_THRESHOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_THRESHOLD - 1);

  logic [CHANNELS-1:0]             sync1_q, sync2_q;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            tick_d, tick_q;
  logic [CHANNELS-1:0][DEPTH-1:0]  shift_q, shift_d;
  logic [CHANNELS-1:0]             out_q, out_d;
  logic [CHANNELS-1:0]             pressed_q, pressed_d;
  logic [CHANNELS-1:0]             released_q, released_d;

  always_comb begin
    tick_d = enable && (cnt_q == CNT_MAX);
    cnt_d  = cnt_q;
    if (enable) begin
      cnt_d = tick_d ? '0 : cnt_q + 1'b1;
    end
  end

  // tick_q marks the cycle after a sample tick, when the freshly shifted history is judged.
  always_comb begin
    shift_d    = shift_q;
    out_d      = out_q;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tick_d) begin
        shift_d[i] = {shift_q[i][DEPTH-2:0], sync2_q[i]};
      end
      if (tick_q) begin
        if (!out_q[i] && (&shift_q[i])) begin
          out_d[i]     = 1'b1;
          pressed_d[i] = 1'b1;
        end else if (out_q[i] && !(|shift_q[i])) begin
          out_d[i]      = 1'b0;
          released_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      shift_q    <= '0;
      out_q      <= '0;
      pressed_q  <= '0;
      released_q <= '0;
    end else begin
      sync1_q    <= buttonIn;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      shift_q    <= shift_d;
      out_q      <= out_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign buttonOut = out_q;
  assign pressed   = pressed_q;
  assign released  = released_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - randomized and directed bench for debouncer_multi
// Reference model tracks run lengths of equal tick samples rather than shift registers.
module tb_debouncer_multi;

  localparam int CH  = 2;
  localparam int DIV = 4;
  localparam int DEP = 3;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [CH-1:0] buttonIn;
  logic [CH-1:0] buttonOut, pressed, released;

  int checks = 0;
  int errors = 0;

  debouncer_multi #(.CHANNELS(CH), .DIV_THRESHOLD(DIV), .DEPTH(DEP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .buttonIn(buttonIn),
    .buttonOut(buttonOut), .pressed(pressed), .released(released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: enabled-edge count, raw input delayed two edges, run length per channel.
  int            ecnt;
  logic [CH-1:0] r1, r2;
  int            run [CH];
  logic          rv  [CH];
  logic          evalp, do_tick;
  logic [CH-1:0] m_out, m_pr, m_rl;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ecnt = 0; r1 = '0; r2 = '0; evalp = 1'b0;
      m_out = '0; m_pr = '0; m_rl = '0;
      for (int c = 0; c < CH; c++) begin rv[c] = 1'b0; run[c] = DEP; end
    end else begin
      do_tick = enable && ((ecnt % DIV) == DIV - 1);
      m_pr = '0; m_rl = '0;
      if (evalp) begin
        for (int c = 0; c < CH; c++) begin
          if (run[c] >= DEP && rv[c] != m_out[c]) begin
            m_out[c] = rv[c];
            if (rv[c]) m_pr[c] = 1'b1; else m_rl[c] = 1'b1;
          end
        end
      end
      if (do_tick) begin
        for (int c = 0; c < CH; c++) begin
          if (r2[c] == rv[c]) begin
            if (run[c] < DEP) run[c] = run[c] + 1;
          end else begin
            rv[c] = r2[c]; run[c] = 1;
          end
        end
      end
      evalp = do_tick;
      if (enable) ecnt = ecnt + 1;
      r2 = r1;
      r1 = buttonIn;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    buttonIn = '0; enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({buttonOut, pressed, released} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got=%b%b%b exp=000000", buttonOut, pressed, released);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      checks++;
      if ({buttonOut, pressed, released} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold t=%0t got out=%b pr=%b rl=%b exp all 0", $time, buttonOut, pressed, released);
      end
    end
  endtask

  // From reset release, ticks land on edges 4, 8, 12; the level appears after edge 13.
  task automatic test_clean_press();
    logic [CH-1:0] eo, ep;
    @(negedge clk);
    reset_n = 1'b0; buttonIn = 2'b01; enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      eo = (k >= 13) ? 2'b01 : 2'b00;
      ep = (k == 13) ? 2'b01 : 2'b00;
      checks++;
      if (buttonOut !== eo || pressed !== ep || released !== 2'b00) begin
        errors++;
        $display("FAIL clean_press edge=%0d got out=%b pr=%b rl=%b exp out=%b pr=%b rl=00", k, buttonOut, pressed, released, eo, ep);
      end
    end
  endtask

  task automatic test_bounce(input logic level);
    logic [3:0] pat;
    int waited;
    do_reset();
    buttonIn = {1'b0, level};
    waited = 0;
    while (m_out[0] !== level && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (buttonOut[0] !== level) begin
      errors++;
      $display("FAIL bounce_setup got=%b exp=%b", buttonOut[0], level);
    end
    while ((ecnt % DIV) != 1) @(negedge clk);
    pat = level ? 4'b0011 : 4'b1100;
    for (int k = 0; k < 90; k++) begin
      buttonIn[0] = (k < 60) ? pat[k % 4] : level;
      @(negedge clk);
      checks++;
      if (buttonOut !== {1'b0, level} || pressed !== 2'b00 || released !== 2'b00 ||
          {buttonOut, pressed, released} !== {m_out, m_pr, m_rl}) begin
        errors++;
        $display("FAIL bounce lvl=%b k=%0d got out=%b pr=%b rl=%b exp out=%b pr=00 rl=00", level, k, buttonOut, pressed, released, {1'b0, level});
      end
    end
  endtask

  task automatic test_release_simul();
    int waited, rl_cnt, split;
    do_reset();
    buttonIn = 2'b11;
    waited = 0;
    while (m_out !== 2'b11 && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (buttonOut !== 2'b11) begin
      errors++;
      $display("FAIL release_setup got=%b exp=11", buttonOut);
    end
    buttonIn = 2'b00;
    rl_cnt = 0; split = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (released == 2'b11) rl_cnt++;
      if (released == 2'b01 || released == 2'b10 || buttonOut == 2'b01 || buttonOut == 2'b10) split++;
      checks++;
      if ({buttonOut, pressed, released} !== {m_out, m_pr, m_rl}) begin
        errors++;
        $display("FAIL release_model k=%0d got out=%b pr=%b rl=%b exp out=%b pr=%b rl=%b", k, buttonOut, pressed, released, m_out, m_pr, m_rl);
      end
    end
    checks++;
    if (rl_cnt !== 1 || split !== 0 || buttonOut !== 2'b00) begin
      errors++;
      $display("FAIL release_simul got pulses=%0d split=%0d out=%b exp pulses=1 split=0 out=00", rl_cnt, split, buttonOut);
    end
  endtask

  task automatic test_enable_freeze();
    int rises;
    do_reset();
    repeat (5) @(negedge clk);
    enable = 1'b0; buttonIn = 2'b10;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if ({buttonOut, pressed, released} !== 6'b0) begin
        errors++;
        $display("FAIL freeze t=%0t got out=%b pr=%b rl=%b exp all 0", $time, buttonOut, pressed, released);
      end
    end
    enable = 1'b1;
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pressed == 2'b10) rises++;
      checks++;
      if ({buttonOut, pressed, released} !== {m_out, m_pr, m_rl}) begin
        errors++;
        $display("FAIL unfreeze_model k=%0d got out=%b pr=%b rl=%b exp out=%b pr=%b rl=%b", k, buttonOut, pressed, released, m_out, m_pr, m_rl);
      end
    end
    checks++;
    if (rises !== 1 || buttonOut !== 2'b10) begin
      errors++;
      $display("FAIL unfreeze got rises=%0d out=%b exp rises=1 out=10", rises, buttonOut);
    end
  endtask

  task automatic test_async_reset();
    int waited;
    do_reset();
    buttonIn = 2'b11;
    waited = 0;
    while (m_out !== 2'b11 && waited < 40) begin @(negedge clk); waited++; end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({buttonOut, pressed, released} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got out=%b pr=%b rl=%b exp all 0", buttonOut, pressed, released);
    end
    buttonIn = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      checks++;
      if ({buttonOut, pressed, released} !== 6'b0) begin
        errors++;
        $display("FAIL post_reset got out=%b pr=%b rl=%b exp all 0", buttonOut, pressed, released);
      end
    end
  endtask

  task automatic test_random();
    int hold [CH];
    do_reset();
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 16);
    repeat (1500) begin
      @(negedge clk);
      checks++;
      if ({buttonOut, pressed, released} !== {m_out, m_pr, m_rl} || (pressed & released) !== 2'b00) begin
        errors++;
        $display("FAIL random t=%0t got out=%b pr=%b rl=%b exp out=%b pr=%b rl=%b", $time, buttonOut, pressed, released, m_out, m_pr, m_rl);
      end
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          buttonIn[c] = ~buttonIn[c];
          hold[c] = $urandom_range(1, 16);
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      enable = ($urandom_range(0, 9) != 0);
    end
    enable = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b1; buttonIn = '0;
    test_reset();
    test_clean_press();
    test_bounce(1'b0);
    test_bounce(1'b1);
    test_release_simul();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
